rggen_bit_field_trigger_pulse: RTL and testbench
================================================

Name: rggen_bit_field_trigger_pulse

Overview:
- Parametrised trigger bit field for rggen register blocks.
- A software write of the trigger value launches a per-bit pulse of programmable length on o_trigger.
- Optionally holds each pulse until a downstream per-bit acknowledge.
- Pending (busy) status is readable back through the bit-field interface.
- Sits between the register-block bit-field interface and hardware consumers such as DMA kicks, soft resets and event launches.

Parameters:
- TRIGGER_VALUE, 1'b1: written data value that fires a trigger (1 = write-1-trigger, 0 = write-0-trigger).
- WIDTH, 1: number of independent trigger bits, 1..64.
- PULSE_WIDTH, 1: minimum o_trigger high time in cycles, 1..256. Elaboration error if out of range.
- HANDSHAKE, 1'b0: 1 = each pulse also holds until the matching i_ack bit is seen.

Ports:
- i_clk, input, 1: clock.
- i_rst, input, 1: reset.
- bit_field_if, interface, rggen_bit_field_if.bit_field: uses valid, write_mask, write_data, read_data, value.
- i_ack, input, WIDTH: per-bit acknowledge. Ignored when HANDSHAKE=0.
- o_trigger, output, WIDTH: per-bit trigger pulse, registered.
- o_busy, output, WIDTH: per-bit pending status. Equals o_trigger.

Interface decisions (fixed): one clock; reset is synchronous and active-high.

Behaviour:
- Reset: synchronous, active-high. i_rst high at an edge forces the following for every bit, overriding valid and i_ack:
  - o_trigger = 0, o_busy = 0
  - state = IDLE, counter = 0, ack_seen = 0
- Per-bit FSM with two states, IDLE and ACTIVE. Bits are fully independent.
- Fire condition for bit i: bit_field_if.valid & write_mask[i] & (write_data[i] == TRIGGER_VALUE).
- IDLE, fire condition true at edge N:
  - go to ACTIVE
  - counter = PULSE_WIDTH-1
  - ack_seen = 0
  - o_trigger[i] high from cycle N+1 (one-cycle latency).
- ACTIVE, each cycle:
  - counter decrements while nonzero, saturating at 0.
  - ack_seen sets if i_ack[i] is high.
  - Exit to IDLE when counter==0 && (!HANDSHAKE || ack_seen || i_ack[i]).
  - o_trigger[i] drops the cycle after the exit condition.
- HANDSHAKE=0: o_trigger high for exactly PULSE_WIDTH cycles, N+1..N+PULSE_WIDTH.
- HANDSHAKE=1: o_trigger high until cycle max(N+PULSE_WIDTH, K), where K is the first cycle ≥ N+1 with i_ack[i] high.
  - An ack in an earlier cycle is remembered.
  - i_ack in IDLE is ignored.
  - There is no timeout.
- Fire condition while ACTIVE (including the last high cycle):
  - The write is dropped.
  - No restart, no extension of the pulse.
- Bits with write_mask=0, or with data != TRIGGER_VALUE, are unaffected.
- bit_field_if.read_data = o_busy, combinational from state.
- bit_field_if.value = o_trigger.
- Reads (valid with write_mask=0) have no side effect.
- Counter width = $clog2(PULSE_WIDTH+1). No wrap-around is possible.

Optional Feature:
- Macro: RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN.
- Defined:
  - Adds output o_overrun [WIDTH], reset 0.
  - Bit i sets one cycle after a fire condition hits while bit i is ACTIVE.
  - Bit i clears one cycle after the next accepted (IDLE) fire for bit i.
  - Set and clear in the same cycle cannot occur.
  - read_data becomes {o_overrun, o_busy} packed as [2*WIDTH-1:WIDTH] = overrun, [WIDTH-1:0] = busy. The bit-field width doubles accordingly.
- Undefined: no o_overrun port; dropped writes leave no trace; read_data = o_busy.

Test Plan:
- Reset and idle: WIDTH=4, PULSE_WIDTH=3, i_rst high for 2 cycles with valid=1, data=4'hF → o_trigger=0, read_data=0 after reset.
- Pulse length: WIDTH=4, TRIGGER_VALUE=1, PULSE_WIDTH=3, write mask=4'h5 data=4'hF at cycle 10 → o_trigger=4'h5 in cycles 11-13, 0 at cycle 14; read_data=4'h5 in cycles 11-13.
- W0 mode: TRIGGER_VALUE=0, PULSE_WIDTH=1, write mask=4'hF data=4'hA at cycle 5 → o_trigger=4'h5 at cycle 6 only.
- Handshake: HANDSHAKE=1, PULSE_WIDTH=2:
  - Fire at cycle 0, i_ack[0] high at cycle 6 → o_trigger[0] high cycles 1-6, low at 7.
  - Second run with ack at cycle 1 → high cycles 1-2 only.
- Retrigger, reset mid-pulse and overrun:
  - PULSE_WIDTH=4, fire at cycle 0, refire at cycles 2 and 4 → single pulse cycles 1-4; with the macro, o_overrun[0]=1 from cycle 3.
  - Then fire at cycle 8 → pulse 9-12, o_overrun[0]=0 from cycle 9.
  - i_rst at cycle 10 → all outputs 0 at cycle 11.
- Independence: WIDTH=2, fire bit0 at cycle 0 and bit1 at cycle 2, PULSE_WIDTH=3 → bit0 high 1-3, bit1 high 3-5.

Source files
------------

// File: rtl/rggen_bit_field_if.sv
// rtl/rggen_bit_field_if.sv - register-block to bit-field connection
interface rggen_bit_field_if #(
  parameter int WIDTH = 1
);
  logic             valid;
  logic [WIDTH-1:0] write_mask;
  logic [WIDTH-1:0] write_data;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] value;

  modport master (
    output valid, write_mask, write_data,
    input  read_data, value
  );

  modport bit_field (
    input  valid, write_mask, write_data,
    output read_data, value
  );
endinterface

// File: rtl/rggen_bit_field_trigger_pulse.sv
// rtl/rggen_bit_field_trigger_pulse.sv - per-bit write-triggered pulse with optional ack hold
// Optional macro: RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN (adds o_overrun, read_data = {overrun, busy}).
module rggen_bit_field_trigger_pulse #(
  parameter logic TRIGGER_VALUE = 1'b1,
  parameter int   WIDTH         = 1,
  parameter int   PULSE_WIDTH   = 1,
  parameter logic HANDSHAKE     = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rggen_bit_field_if.bit_field bit_field_if,
  input  logic [WIDTH-1:0]     i_ack,
  output logic [WIDTH-1:0]     o_trigger,
  output logic [WIDTH-1:0]     o_busy
`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
  ,
  output logic [WIDTH-1:0]     o_overrun
`endif
);

`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
  localparam int FIELD_WIDTH = 2 * WIDTH;
`else
  localparam int FIELD_WIDTH = WIDTH;
`endif
  localparam int COUNT_WIDTH = $clog2(PULSE_WIDTH + 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(PULSE_WIDTH - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("rggen_bit_field_trigger_pulse: WIDTH must be 1..64");
  end
  if (PULSE_WIDTH < 1 || PULSE_WIDTH > 256) begin : g_bad_pulse_width
    $error("rggen_bit_field_trigger_pulse: PULSE_WIDTH must be 1..256");
  end

  logic [WIDTH-1:0] w_fire;

  assign w_fire = {WIDTH{bit_field_if.valid}}
                & bit_field_if.write_mask[WIDTH-1:0]
                & ~(bit_field_if.write_data[WIDTH-1:0] ^ {WIDTH{TRIGGER_VALUE}});

`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
  // Upper half of the field is the read-only overrun status; writes there do nothing.
  logic w_unused_upper;
  assign w_unused_upper = ^{bit_field_if.write_mask[FIELD_WIDTH-1:WIDTH],
                            bit_field_if.write_data[FIELD_WIDTH-1:WIDTH]};
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    state_e                 r_state;
    state_e                 w_state_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_next;
    logic                   r_ack_seen;
    logic                   w_ack_seen_next;
    logic                   w_exit;

    // Same-cycle ack counts, so the pulse can end on the first cycle it is seen.
    assign w_exit = (r_count == '0) && (!HANDSHAKE || r_ack_seen || i_ack[g]);

    always_comb begin
      w_state_next    = r_state;
      w_count_next    = r_count;
      w_ack_seen_next = r_ack_seen;
      case (r_state)
        ST_IDLE: begin
          if (w_fire[g]) begin
            w_state_next    = ST_ACTIVE;
            w_count_next    = COUNT_LOAD;
            w_ack_seen_next = 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (r_count != '0) begin
            w_count_next = r_count - COUNT_WIDTH'(1);
          end
          if (i_ack[g]) begin
            w_ack_seen_next = 1'b1;
          end
          if (w_exit) begin
            w_state_next    = ST_IDLE;
            w_ack_seen_next = 1'b0;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_state    <= ST_IDLE;
        r_count    <= '0;
        r_ack_seen <= 1'b0;
      end else begin
        r_state    <= w_state_next;
        r_count    <= w_count_next;
        r_ack_seen <= w_ack_seen_next;
      end
    end

    assign o_trigger[g] = (r_state == ST_ACTIVE);

`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
    logic r_overrun;

    // Any fire updates the flag: dropped (ACTIVE) sets it, accepted (IDLE) clears it.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_overrun <= 1'b0;
      end else if (w_fire[g]) begin
        r_overrun <= (r_state == ST_ACTIVE);
      end
    end

    assign o_overrun[g] = r_overrun;
`endif
  end

  assign o_busy = o_trigger;

`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
  assign bit_field_if.read_data = {o_overrun, o_busy};
  assign bit_field_if.value     = {{WIDTH{1'b0}}, o_trigger};
`else
  assign bit_field_if.read_data = o_busy;
  assign bit_field_if.value     = o_trigger;
`endif

endmodule

// File: tb/tb_rggen_bit_field_trigger_pulse.sv
// tb/tb_rggen_bit_field_trigger_pulse.sv - scoreboard bench for rggen_bit_field_trigger_pulse
module tb_rggen_bit_field_trigger_pulse;

`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
  localparam int OVR = 1;
`else
  localparam int OVR = 0;
`endif
  localparam int FW4 = 4 * (1 + OVR);
  localparam int FW1 = 1 + OVR;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst;
  logic [3:0] ack_a, ack_b;
  logic       ack_c, ack_d;
  logic [3:0] trig_a, busy_a, trig_b, busy_b;
  logic       trig_c, busy_c, trig_d, busy_d;
  logic [3:0] ovr_a, ovr_b;
  logic       ovr_c, ovr_d;

  rggen_bit_field_if #(.WIDTH(FW4)) ifa ();
  rggen_bit_field_if #(.WIDTH(FW4)) ifb ();
  rggen_bit_field_if #(.WIDTH(FW1)) ifc ();
  rggen_bit_field_if #(.WIDTH(FW1)) ifd ();

  rggen_bit_field_trigger_pulse #(
    .TRIGGER_VALUE(1'b1), .WIDTH(4), .PULSE_WIDTH(3), .HANDSHAKE(1'b0)
  ) u_a (
    .i_clk(clk), .i_rst(rst[0]), .bit_field_if(ifa), .i_ack(ack_a),
    .o_trigger(trig_a), .o_busy(busy_a)
`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
    , .o_overrun(ovr_a)
`endif
  );

  rggen_bit_field_trigger_pulse #(
    .TRIGGER_VALUE(1'b0), .WIDTH(4), .PULSE_WIDTH(1), .HANDSHAKE(1'b0)
  ) u_b (
    .i_clk(clk), .i_rst(rst[1]), .bit_field_if(ifb), .i_ack(ack_b),
    .o_trigger(trig_b), .o_busy(busy_b)
`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
    , .o_overrun(ovr_b)
`endif
  );

  rggen_bit_field_trigger_pulse #(
    .TRIGGER_VALUE(1'b1), .WIDTH(1), .PULSE_WIDTH(2), .HANDSHAKE(1'b1)
  ) u_c (
    .i_clk(clk), .i_rst(rst[2]), .bit_field_if(ifc), .i_ack(ack_c),
    .o_trigger(trig_c), .o_busy(busy_c)
`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
    , .o_overrun(ovr_c)
`endif
  );

  rggen_bit_field_trigger_pulse #(
    .TRIGGER_VALUE(1'b1), .WIDTH(1), .PULSE_WIDTH(4), .HANDSHAKE(1'b0)
  ) u_d (
    .i_clk(clk), .i_rst(rst[3]), .bit_field_if(ifd), .i_ack(ack_d),
    .o_trigger(trig_d), .o_busy(busy_d)
`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
    , .o_overrun(ovr_d)
`endif
  );

  // Observation views: kind 0 trig, 1 read_data low, 2 overrun, 3 value, 4 read_data high, 5 busy
  logic [3:0] obs [4][6];

  assign obs[0][0] = trig_a;
  assign obs[1][0] = trig_b;
  assign obs[2][0] = {3'b0, trig_c};
  assign obs[3][0] = {3'b0, trig_d};
  assign obs[0][1] = ifa.read_data[3:0];
  assign obs[1][1] = ifb.read_data[3:0];
  assign obs[2][1] = {3'b0, ifc.read_data[0]};
  assign obs[3][1] = {3'b0, ifd.read_data[0]};
  assign obs[0][3] = ifa.value[3:0];
  assign obs[1][3] = ifb.value[3:0];
  assign obs[2][3] = {3'b0, ifc.value[0]};
  assign obs[3][3] = {3'b0, ifd.value[0]};
  assign obs[0][5] = busy_a;
  assign obs[1][5] = busy_b;
  assign obs[2][5] = {3'b0, busy_c};
  assign obs[3][5] = {3'b0, busy_d};
`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
  assign obs[0][2] = ovr_a;
  assign obs[1][2] = ovr_b;
  assign obs[2][2] = {3'b0, ovr_c};
  assign obs[3][2] = {3'b0, ovr_d};
  assign obs[0][4] = ifa.read_data[7:4];
  assign obs[1][4] = ifb.read_data[7:4];
  assign obs[2][4] = {3'b0, ifc.read_data[1]};
  assign obs[3][4] = {3'b0, ifd.read_data[1]};
`else
  assign ovr_a = 4'h0;
  assign ovr_b = 4'h0;
  assign ovr_c = 1'b0;
  assign ovr_d = 1'b0;
  for (genvar i = 0; i < 4; i++) begin : g_no_ovr
    assign obs[i][2] = 4'h0;
    assign obs[i][4] = 4'h0;
  end
`endif

  typedef struct {
    int         cyc;
    int         inst;
    int         kind;
    logic [3:0] exp;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int inst, input int kind, input logic [3:0] v, input string tag);
    exp_t e;
    e.cyc  = cyc;
    e.inst = inst;
    e.kind = kind;
    e.exp  = v;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic expect_out(input int inst, input logic [3:0] trig, input logic [3:0] ovr,
                            input string tag);
    push_exp(inst, 0, trig, {tag, "_trig"});
    push_exp(inst, 1, trig, {tag, "_rd"});
    push_exp(inst, 3, trig, {tag, "_value"});
    push_exp(inst, 5, trig, {tag, "_busy"});
`ifdef RGGEN_BIT_FIELD_TRIGGER_OVERRUN_EN
    push_exp(inst, 2, ovr, {tag, "_ovr"});
    push_exp(inst, 4, ovr, {tag, "_rdovr"});
`else
    if (ovr !== ovr) push_exp(inst, 2, ovr, tag);
`endif
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc != cyc) check_eq({"sb_late_", e.tag}, 32'(cyc), 32'(e.cyc));
      check_eq(e.tag, 32'(obs[e.inst][e.kind]), 32'(e.exp));
    end
  end

  task automatic idle_all();
    rst = 4'h0;
    ack_a = 4'h0; ack_b = 4'h0; ack_c = 1'b0; ack_d = 1'b0;
    ifa.valid = 1'b0; ifa.write_mask = '0; ifa.write_data = '0;
    ifb.valid = 1'b0; ifb.write_mask = '0; ifb.write_data = '0;
    ifc.valid = 1'b0; ifc.write_mask = '0; ifc.write_data = '0;
    ifd.valid = 1'b0; ifd.write_mask = '0; ifd.write_data = '0;
  endtask

  task automatic drive(input int inst, input logic [3:0] m, input logic [3:0] d);
    case (inst)
      0: begin ifa.valid = 1'b1; ifa.write_mask = FW4'(m); ifa.write_data = FW4'(d); end
      1: begin ifb.valid = 1'b1; ifb.write_mask = FW4'(m); ifb.write_data = FW4'(d); end
      2: begin ifc.valid = 1'b1; ifc.write_mask = FW1'(m[0]); ifc.write_data = FW1'(d[0]); end
      default: begin ifd.valid = 1'b1; ifd.write_mask = FW1'(m[0]); ifd.write_data = FW1'(d[0]); end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    idle_all();
  endtask

  function automatic logic [3:0] win(input int t, input int lo, input int hi, input logic [3:0] v);
    return (t >= lo && t <= hi) ? v : 4'h0;
  endfunction

  initial begin
    idle_all();
    // Reset held two cycles with every bit being written its trigger value.
    rst = 4'hF;
    for (int i = 0; i < 4; i++) drive(i, 4'hF, 4'hF);
    tick();
    rst = 4'hF;
    for (int i = 0; i < 4; i++) drive(i, 4'hF, 4'hF);
    for (int i = 0; i < 4; i++) expect_out(i, 4'h0, 4'h0, $sformatf("rst_hold%0d", i));
    for (int t = 0; t < 2; t++) begin
      tick();
      for (int i = 0; i < 4; i++) expect_out(i, 4'h0, 4'h0, $sformatf("rst_post%0d_t%0d", i, t));
    end

    // Pulse length, read without side effect, non-trigger data.
    for (int t = 0; t <= 6; t++) begin
      tick();
      if (t == 0) drive(0, 4'h5, 4'hF);
      if (t == 2) drive(0, 4'h0, 4'hF);
      if (t == 4) drive(0, 4'hF, 4'h0);
      expect_out(0, win(t, 1, 3, 4'h5), 4'h0, $sformatf("pulse_t%0d", t));
    end

    // Independent bits.
    for (int t = 0; t <= 6; t++) begin
      tick();
      if (t == 0) drive(0, 4'h1, 4'h1);
      if (t == 2) drive(0, 4'h2, 4'h2);
      expect_out(0, win(t, 1, 3, 4'h1) | win(t, 3, 5, 4'h2), 4'h0, $sformatf("indep_t%0d", t));
    end

    // Write-0 trigger, PULSE_WIDTH=1, fire on the last high cycle is dropped.
    for (int t = 0; t <= 4; t++) begin
      tick();
      if (t <= 2) drive(1, 4'hF, 4'hA);
      expect_out(1, win(t, 1, 1, 4'h5) | win(t, 3, 3, 4'h5), win(t, 2, 2, 4'h5),
                 $sformatf("w0_t%0d", t));
    end

    // Handshake: ack in IDLE ignored, late ack holds the pulse.
    for (int t = 0; t <= 8; t++) begin
      tick();
      if (t == 0) drive(2, 4'h1, 4'h1);
      ack_c = (t == 0 || t == 6);
      expect_out(2, win(t, 1, 6, 4'h1), 4'h0, $sformatf("hs_late_t%0d", t));
    end
    // Handshake: early ack remembered.
    for (int t = 0; t <= 4; t++) begin
      tick();
      if (t == 0) drive(2, 4'h1, 4'h1);
      ack_c = (t == 1);
      expect_out(2, win(t, 1, 2, 4'h1), 4'h0, $sformatf("hs_early_t%0d", t));
    end
    // Handshake with a dropped refire, then a fresh accepted fire.
    for (int t = 0; t <= 9; t++) begin
      tick();
      if (t == 0 || t == 2 || t == 5) drive(2, 4'h1, 4'h1);
      ack_c = (t == 3 || t == 6);
      expect_out(2, win(t, 1, 3, 4'h1) | win(t, 6, 7, 4'h1), win(t, 3, 5, 4'h1),
                 $sformatf("hs_refire_t%0d", t));
    end

    // Retrigger ignored, overrun, then reset mid-pulse overriding a write.
    for (int t = 0; t <= 13; t++) begin
      tick();
      if (t == 0 || t == 2 || t == 4 || t == 8 || t == 10) drive(3, 4'h1, 4'h1);
      if (t == 10) rst[3] = 1'b1;
      expect_out(3, win(t, 1, 4, 4'h1) | win(t, 9, 10, 4'h1), win(t, 3, 8, 4'h1),
                 $sformatf("retrig_t%0d", t));
    end

    tick();
    @(negedge clk);
    #1;
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
